// File: rtl/aria_round_seq.sv
// ARIA round sequencer: key-expansion words, round-key addressing and last-round control
// for 128/192/256-bit keys, with a start/busy/done handshake plus hold and abort.
module aria_round_seq #(
  parameter int ADDR_W   = 5,
  parameter int RND_W    = 4,
  parameter int NR_128   = 12,
  parameter int NR_192   = 14,
  parameter int NR_256   = 16,
  parameter int KEXP_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dec,
  input  logic [1:0]        aria_mode,
  input  logic              hold,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [1:0]        w_cnt,
  output logic              w_valid,
  output logic [ADDR_W-1:0] rk_addr,
  output logic              rk_valid,
  output logic [RND_W-1:0]  round_cnt,
  output logic              sl_type,
  output logic              diff_bypass,
  output logic              final_key
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEXP,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  state_t            state;
  logic              dec_q;
  logic [ADDR_W-1:0] nr_q;
  logic [ADDR_W-1:0] nr_sel;
  logic [ADDR_W-1:0] nr_last;
  logic [ADDR_W-1:0] rnd_ext;

  always_comb begin
    nr_sel = ADDR_W'(NR_256);
    case (aria_mode)
      2'b00:   nr_sel = ADDR_W'(NR_128);
      2'b01:   nr_sel = ADDR_W'(NR_192);
      default: nr_sel = ADDR_W'(NR_256);
    endcase
  end

  assign nr_last = nr_q - ADDR_W'(1);
  assign rnd_ext = ADDR_W'(round_cnt);
  assign sl_type = round_cnt[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dec_q       <= 1'b0;
      nr_q        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      w_cnt       <= '0;
      w_valid     <= 1'b0;
      rk_addr     <= '0;
      rk_valid    <= 1'b0;
      round_cnt   <= '0;
      diff_bypass <= 1'b0;
      final_key   <= 1'b0;
    end else if (abort) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      w_cnt       <= '0;
      w_valid     <= 1'b0;
      rk_addr     <= '0;
      rk_valid    <= 1'b0;
      round_cnt   <= '0;
      diff_bypass <= 1'b0;
      final_key   <= 1'b0;
    end else if (!hold) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_KEXP;
            dec_q   <= dec;
            nr_q    <= nr_sel;
            busy    <= 1'b1;
            w_valid <= 1'b1;
            w_cnt   <= '0;
          end
        end
        S_KEXP: begin
          if (w_cnt == 2'(KEXP_CYC - 1)) begin
            state       <= S_ROUND;
            w_valid     <= 1'b0;
            rk_valid    <= 1'b1;
            round_cnt   <= '0;
            rk_addr     <= dec_q ? nr_q : '0;
            diff_bypass <= (nr_q == ADDR_W'(1));
          end else begin
            w_cnt <= w_cnt + 2'd1;
          end
        end
        S_ROUND: begin
          if (rnd_ext == nr_last) begin
            state       <= S_FINAL;
            rk_addr     <= dec_q ? '0 : nr_q;
            final_key   <= 1'b1;
            diff_bypass <= 1'b0;
          end else begin
            round_cnt   <= round_cnt + RND_W'(1);
            rk_addr     <= dec_q ? rk_addr - ADDR_W'(1) : rk_addr + ADDR_W'(1);
            // Registered flag: it must be high while the last round index is presented.
            diff_bypass <= (rnd_ext + ADDR_W'(1) == nr_last);
          end
        end
        S_FINAL: begin
          state     <= S_DONE;
          rk_valid  <= 1'b0;
          final_key <= 1'b0;
          done      <= 1'b1;
        end
        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          w_cnt     <= '0;
          round_cnt <= '0;
          rk_addr   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aria_round_seq.sv
// Scoreboard bench for aria_round_seq: per-cycle expected output records are queued
// when an operation is launched and compared against the DUT one cycle at a time.
module tb_aria_round_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dec = 1'b0;
  logic [1:0] aria_mode = 2'b00;
  logic       hold = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, w_valid, rk_valid, sl_type, diff_bypass, final_key;
  logic [1:0] w_cnt;
  logic [4:0] rk_addr;
  logic [3:0] round_cnt;

  aria_round_seq #(
    .ADDR_W(5), .RND_W(4), .NR_128(12), .NR_192(14), .NR_256(16), .KEXP_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dec(dec), .aria_mode(aria_mode),
    .hold(hold), .abort(abort), .busy(busy), .done(done), .w_cnt(w_cnt),
    .w_valid(w_valid), .rk_addr(rk_addr), .rk_valid(rk_valid), .round_cnt(round_cnt),
    .sl_type(sl_type), .diff_bypass(diff_bypass), .final_key(final_key)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       w_valid;
    logic       rk_valid;
    logic       diff_bypass;
    logic       final_key;
    logic [1:0] w_cnt;
    logic [4:0] rk_addr;
    logic [3:0] round_cnt;
    logic       sl_type;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  function automatic exp_t actual();
    exp_t a;
    a.busy = busy; a.done = done; a.w_valid = w_valid; a.rk_valid = rk_valid;
    a.diff_bypass = diff_bypass; a.final_key = final_key; a.w_cnt = w_cnt;
    a.rk_addr = rk_addr; a.round_cnt = round_cnt; a.sl_type = sl_type;
    return a;
  endfunction

  // Index fields are only meaningful while their phase is active.
  function automatic exp_t masked(exp_t v);
    exp_t m = v;
    if (!m.w_valid) m.w_cnt = '0;
    if (!m.rk_valid) m.rk_addr = '0;
    if (!(m.rk_valid && !m.final_key)) begin
      m.round_cnt = '0;
      m.sl_type   = 1'b0;
    end
    return m;
  endfunction

  task automatic push_op(input int nr, input bit d, input int hold_round, input int hold_len);
    exp_t e;
    for (int w = 0; w < 4; w++) begin
      e = '0; e.busy = 1'b1; e.w_valid = 1'b1; e.w_cnt = 2'(w);
      exp_q.push_back(e);
    end
    for (int r = 0; r < nr; r++) begin
      e = '0; e.busy = 1'b1; e.rk_valid = 1'b1;
      e.round_cnt = 4'(r); e.sl_type = r[0];
      e.rk_addr = d ? 5'(nr - r) : 5'(r);
      e.diff_bypass = (r == nr - 1);
      exp_q.push_back(e);
      if (r == hold_round) repeat (hold_len) exp_q.push_back(e);
    end
    e = '0; e.busy = 1'b1; e.rk_valid = 1'b1; e.final_key = 1'b1;
    e.rk_addr = d ? 5'd0 : 5'(nr);
    exp_q.push_back(e);
    e = '0; e.busy = 1'b1; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_idle();
    exp_q.push_back('0);
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (actual() !== exp_t'('0)) $display("FAIL reset_outputs: got %h expected %h", actual(), exp_t'('0));
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (actual() !== exp_t'('0)) $display("FAIL reset_idle: got %h expected %h", actual(), exp_t'('0));
    else passed++;
  endtask

  task automatic test_enc128();
    exp_t e; int c = 0; int done_cyc = -1; int diff_cyc = -1;
    dec = 1'b0; aria_mode = 2'b00; start = 1'b1;
    push_op(12, 1'b0, -1, 0); push_idle();
    while (exp_q.size() > 0) begin
      @(posedge clk); #1; c++; start = 1'b0;
      e = exp_q.pop_front(); total++;
      if (masked(actual()) !== masked(e))
        $display("FAIL enc128_trace cyc %0d: got %h expected %h", c, masked(actual()), masked(e));
      else passed++;
      if (done && done_cyc < 0) done_cyc = c;
      if (diff_bypass && diff_cyc < 0) diff_cyc = c;
    end
    total++;
    if (done_cyc !== 18) $display("FAIL enc128_done_cycle: got %0d expected 18", done_cyc);
    else passed++;
    total++;
    if (diff_cyc !== 16) $display("FAIL enc128_diff_cycle: got %0d expected 16", diff_cyc);
    else passed++;
  endtask

  task automatic test_dec256();
    exp_t e; int c = 0;
    dec = 1'b1; aria_mode = 2'b10; start = 1'b1;
    push_op(16, 1'b1, -1, 0); push_idle();
    while (exp_q.size() > 0) begin
      @(posedge clk); #1; c++; start = 1'b0;
      e = exp_q.pop_front(); total++;
      if (masked(actual()) !== masked(e))
        $display("FAIL dec256_trace cyc %0d: got %h expected %h", c, masked(actual()), masked(e));
      else passed++;
    end
  endtask

  task automatic test_hold();
    exp_t e; int c = 0; int done_cyc = -1;
    dec = 1'b0; aria_mode = 2'b01; start = 1'b1;
    push_op(14, 1'b0, 5, 3); push_idle();
    while (exp_q.size() > 0) begin
      @(posedge clk); #1; c++; start = 1'b0;
      e = exp_q.pop_front(); total++;
      if (masked(actual()) !== masked(e))
        $display("FAIL hold_trace cyc %0d: got %h expected %h", c, masked(actual()), masked(e));
      else passed++;
      if (done && done_cyc < 0) done_cyc = c;
      if (c == 10) hold = 1'b1;
      if (c == 13) hold = 1'b0;
    end
    total++;
    if (done_cyc !== 23) $display("FAIL hold_done_cycle: got %0d expected 23", done_cyc);
    else passed++;
  endtask

  task automatic test_abort();
    exp_t e; int c = 0;
    dec = 1'b0; aria_mode = 2'b00; start = 1'b1;
    push_op(12, 1'b0, -1, 0);
    while (c < 12) begin
      @(posedge clk); #1; c++; start = 1'b0;
      e = exp_q.pop_front(); total++;
      if (masked(actual()) !== masked(e))
        $display("FAIL abort_pre cyc %0d: got %h expected %h", c, masked(actual()), masked(e));
      else passed++;
    end
    exp_q.delete();
    abort = 1'b1; hold = 1'b1;
    @(posedge clk); #1;
    total++;
    if (actual() !== exp_t'('0)) $display("FAIL abort_idle: got %h expected %h", actual(), exp_t'('0));
    else passed++;
    hold = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    total++;
    if (actual() !== exp_t'('0)) $display("FAIL abort_beats_start: got %h expected %h", actual(), exp_t'('0));
    else passed++;
    abort = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (actual() !== exp_t'('0)) $display("FAIL abort_stays_idle: got %h expected %h", actual(), exp_t'('0));
    else passed++;
    c = 0; dec = 1'b1; aria_mode = 2'b01; start = 1'b1;
    push_op(14, 1'b1, -1, 0); push_idle();
    while (exp_q.size() > 0) begin
      @(posedge clk); #1; c++; start = 1'b0;
      e = exp_q.pop_front(); total++;
      if (masked(actual()) !== masked(e))
        $display("FAIL abort_rerun cyc %0d: got %h expected %h", c, masked(actual()), masked(e));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int c = 0; int dones = 0;
    dec = 1'b0; aria_mode = 2'b00; start = 1'b1;
    push_op(12, 1'b0, -1, 0); push_idle();
    push_op(12, 1'b0, -1, 0); push_idle();
    while (exp_q.size() > 0) begin
      @(posedge clk); #1; c++;
      e = exp_q.pop_front(); total++;
      if (masked(actual()) !== masked(e))
        $display("FAIL b2b_trace cyc %0d: got %h expected %h", c, masked(actual()), masked(e));
      else passed++;
      if (done) dones++;
      if (c == 5) begin aria_mode = 2'b10; dec = 1'b1; end
      if (c == 15) begin aria_mode = 2'b00; dec = 1'b0; end
      if (c == 20) start = 1'b0;
    end
    total++;
    if (dones !== 2) $display("FAIL b2b_done_count: got %0d expected 2", dones);
    else passed++;
  endtask

  task automatic test_async_reset();
    exp_t e; int c = 0; int done_cyc = -1;
    dec = 1'b0; aria_mode = 2'b00; start = 1'b1;
    push_op(12, 1'b0, -1, 0);
    while (c < 3) begin
      @(posedge clk); #1; c++; start = 1'b0;
      e = exp_q.pop_front(); total++;
      if (masked(actual()) !== masked(e))
        $display("FAIL arst_pre cyc %0d: got %h expected %h", c, masked(actual()), masked(e));
      else passed++;
    end
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (actual() !== exp_t'('0)) $display("FAIL arst_outputs: got %h expected %h", actual(), exp_t'('0));
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    c = 0; dec = 1'b0; aria_mode = 2'b11; start = 1'b1;
    push_op(16, 1'b0, -1, 0); push_idle();
    while (exp_q.size() > 0) begin
      @(posedge clk); #1; c++; start = 1'b0;
      e = exp_q.pop_front(); total++;
      if (masked(actual()) !== masked(e))
        $display("FAIL arst_mode11 cyc %0d: got %h expected %h", c, masked(actual()), masked(e));
      else passed++;
      if (done && done_cyc < 0) done_cyc = c;
    end
    total++;
    if (done_cyc !== 22) $display("FAIL arst_mode11_done: got %0d expected 22", done_cyc);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_enc128();
    test_dec256();
    test_hold();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
